// File: rtl/alu_pkg.sv
// Shared constants and types for the execute-stage ALU control and mul/div engine.
package alu_pkg;

  // Main-decoder ALU ops; anything else is treated as R-type.
  localparam logic [3:0] ALUOP_ADD   = 4'b0000;
  localparam logic [3:0] ALUOP_SUB   = 4'b0001;
  localparam logic [3:0] ALUOP_BLEZ  = 4'b0010;
  localparam logic [3:0] ALUOP_ORI   = 4'b0011;
  localparam logic [3:0] ALUOP_LUI   = 4'b0100;
  localparam logic [3:0] ALUOP_XORI  = 4'b0101;
  localparam logic [3:0] ALUOP_SLTI  = 4'b0110;
  localparam logic [3:0] ALUOP_ANDI  = 4'b0111;
  localparam logic [3:0] ALUOP_BGTZ  = 4'b1000;
  localparam logic [3:0] ALUOP_RTYPE = 4'b1111;

  // ALU control words.
  localparam logic [3:0] ALUCTRL_AND  = 4'b0000;
  localparam logic [3:0] ALUCTRL_OR   = 4'b0001;
  localparam logic [3:0] ALUCTRL_ADD  = 4'b0010;
  localparam logic [3:0] ALUCTRL_SLL  = 4'b0011;
  localparam logic [3:0] ALUCTRL_SUB  = 4'b0110;
  localparam logic [3:0] ALUCTRL_SLT  = 4'b0111;
  localparam logic [3:0] ALUCTRL_LUI  = 4'b1000;
  localparam logic [3:0] ALUCTRL_XOR  = 4'b1001;
  localparam logic [3:0] ALUCTRL_BLEZ = 4'b1010;
  localparam logic [3:0] ALUCTRL_SRLV = 4'b1011;
  localparam logic [3:0] ALUCTRL_SRL  = 4'b1100;
  localparam logic [3:0] ALUCTRL_BGTZ = 4'b1101;

  // R-type funct codes.
  localparam logic [5:0] FUNCT_SLL   = 6'b000000;
  localparam logic [5:0] FUNCT_SRL   = 6'b000010;
  localparam logic [5:0] FUNCT_SRLV  = 6'b000110;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;

  // Execute result mux selects.
  localparam logic [1:0] RSEL_ALU = 2'b00;
  localparam logic [1:0] RSEL_HI  = 2'b01;
  localparam logic [1:0] RSEL_LO  = 2'b10;

  typedef enum logic [1:0] {IDLE, MUL, DIV} md_state_t;

  // Encoding matches funct[1:0] of the mult/multu/div/divu group.
  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_t;

endpackage

// File: rtl/muldiv_core.sv
// Iterative shift-add multiplier / restoring divider with HI/LO registers.
module muldiv_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned AW    = 2 * WIDTH;

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]    acc;       // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0] dsr;       // multiplicand or divisor magnitude
  logic             neg_res;
  logic             neg_rem;
  logic             div_zero;
  logic [WIDTH-1:0] a_raw;

  logic             sgn;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] mcand_sel;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   trial;
  logic [AW-1:0]    acc_nxt;
  logic [AW-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             last;

  // Operand magnitudes at issue, one iteration step, and final sign fix-up.
  always_comb begin
    sgn       = (op == MD_MULT) || (op == MD_DIV);
    a_mag     = (sgn && a[WIDTH-1]) ? -a : a;
    b_mag     = (sgn && b[WIDTH-1]) ? -b : b;
    mcand_sel = acc[0] ? dsr : '0;
    add_sum   = {1'b0, acc[AW-1:WIDTH]} + {1'b0, mcand_sel};
    trial     = {acc[AW-1:WIDTH], acc[WIDTH-1]} - {1'b0, dsr};
    acc_nxt   = acc;
    if (state == MUL) begin
      acc_nxt = {add_sum, acc[WIDTH-1:1]};
    end else if (state == DIV) begin
      acc_nxt = trial[WIDTH] ? {acc[AW-2:0], 1'b0}
                             : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
    prod_fix = neg_res ? -acc_nxt : acc_nxt;
    quo_fix  = neg_res ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc_nxt[AW-1:WIDTH] : acc_nxt[AW-1:WIDTH];
    last     = (cnt == CNT_W'(WIDTH - 1));
  end

  // Engine FSM, iteration datapath and architectural HI/LO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      dsr      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      a_raw    <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt      <= '0;
            busy     <= 1'b1;
            neg_res  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem  <= sgn && a[WIDTH-1];
            div_zero <= (b == '0);
            a_raw    <= a;
            if (op == MD_MULT || op == MD_MULTU) begin
              state <= MUL;
              acc   <= {{WIDTH{1'b0}}, b_mag};
              dsr   <= a_mag;
            end else begin
              state <= DIV;
              acc   <= {{WIDTH{1'b0}}, a_mag};
              dsr   <= b_mag;
            end
          end else begin
            if (wr_hi) hi <= a;
            if (wr_lo) lo <= a;
          end
        end
        MUL, DIV: begin
          acc <= acc_nxt;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (state == MUL) begin
              {hi, lo} <= prod_fix;
            end else if (div_zero) begin
              hi <= a_raw;
              lo <= '1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_md.sv
// Execute-stage ALU control decode plus HI/LO hazard stall around the mul/div engine.
module alu_ctrl_md
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid,
  input  logic [3:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       alucontrol,
  output logic             illegal,
  output logic [1:0]       result_sel,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic rtype;
  logic known;
  logic hilo;
  logic is_md;
  logic accept;
  logic start;
  logic wr_hi;
  logic wr_lo;

  // ALU control decode, HI/LO group classification and hazard stall.
  always_comb begin
    rtype      = 1'b0;
    known      = 1'b1;
    hilo       = 1'b0;
    is_md      = 1'b0;
    alucontrol = ALUCTRL_AND;
    result_sel = RSEL_ALU;
    case (aluop)
      ALUOP_ADD:  alucontrol = ALUCTRL_ADD;
      ALUOP_SUB:  alucontrol = ALUCTRL_SUB;
      ALUOP_BLEZ: alucontrol = ALUCTRL_BLEZ;
      ALUOP_ORI:  alucontrol = ALUCTRL_OR;
      ALUOP_LUI:  alucontrol = ALUCTRL_LUI;
      ALUOP_XORI: alucontrol = ALUCTRL_XOR;
      ALUOP_SLTI: alucontrol = ALUCTRL_SLT;
      ALUOP_ANDI: alucontrol = ALUCTRL_AND;
      ALUOP_BGTZ: alucontrol = ALUCTRL_BGTZ;
      default:    rtype      = 1'b1;
    endcase
    if (rtype) begin
      case (funct)
        FUNCT_SLL:  alucontrol = ALUCTRL_SLL;
        FUNCT_ADD:  alucontrol = ALUCTRL_ADD;
        FUNCT_SUB:  alucontrol = ALUCTRL_SUB;
        FUNCT_AND:  alucontrol = ALUCTRL_AND;
        FUNCT_OR:   alucontrol = ALUCTRL_OR;
        FUNCT_SLT:  alucontrol = ALUCTRL_SLT;
        FUNCT_SRL:  alucontrol = ALUCTRL_SRL;
        FUNCT_SRLV: alucontrol = ALUCTRL_SRLV;
        FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: begin
          hilo  = 1'b1;
          is_md = 1'b1;
        end
        FUNCT_MFHI: begin
          hilo       = 1'b1;
          result_sel = RSEL_HI;
        end
        FUNCT_MFLO: begin
          hilo       = 1'b1;
          result_sel = RSEL_LO;
        end
        FUNCT_MTHI, FUNCT_MTLO: hilo = 1'b1;
        default: known = 1'b0;
      endcase
    end
    illegal = valid && rtype && !known;
    stall   = valid && busy && hilo;
    accept  = valid && !stall;
    start   = accept && is_md;
    wr_hi   = accept && rtype && (funct == FUNCT_MTHI);
    wr_lo   = accept && rtype && (funct == FUNCT_MTLO);
  end

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (md_op_t'(funct[1:0])),
    .a       (a),
    .b       (b),
    .wr_hi   (wr_hi),
    .wr_lo   (wr_lo),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

endmodule
